// File: rtl/pitch_seq_unit_filter.sv
// Sequenced Unit Header filter in front of the PITCH parser: forwards or drops whole packets by unit/sequence.
// Optional statistics counters are built only when PITCH_SEQ_STATS_EN is defined.
module pitch_seq_unit_filter #(
  parameter int UNIT_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              Clk40,
  input  logic              reset,
  input  logic [UNIT_W-1:0] cfg_unit,
  input  logic              seq_resync,
  input  logic [63:0]       s_bytes,
  input  logic [7:0]        s_byte_enables,
  input  logic              s_data_valid,
  output logic              s_ready,
  output logic [63:0]       m_bytes,
  output logic [7:0]        m_byte_enables,
  output logic              m_data_valid,
  input  logic              m_ready,
  output logic              gap_pulse,
  output logic              dup_pulse,
  output logic              len_err_pulse,
  output logic [CNT_W-1:0]  gap_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic [1:0]        dbg_state
);
  // Handshake: a beat moves on either side only in a cycle where its valid and ready are both high.
  typedef enum logic [1:0] {HDR = 2'd0, FWD = 2'd1, DROP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] expected_q, expected_d;
  logic        synced_q, synced_d;
  logic [15:0] remaining_q, remaining_d;
  logic        m_valid_q, m_valid_d, skid_valid_q, skid_valid_d;
  logic [63:0] m_bytes_q, m_bytes_d, skid_bytes_q, skid_bytes_d;
  logic [7:0]  m_en_q, m_en_d, skid_en_q, skid_en_d;
  logic        gap_q, gap_d, dup_q, dup_d, len_err_q, len_err_d;
  logic        drop_inc, emit, fwd, accept, out_ready;
  logic [7:0]  emit_en, rem_mask;
  logic [15:0] hdr_len, step;
  logic [31:0] hdr_seq, seq_next, gap_diff, dup_diff;

  assign accept   = s_data_valid && s_ready;
  assign hdr_len  = s_bytes[15:0];
  assign hdr_seq  = s_bytes[63:32];
  assign seq_next = hdr_seq + {24'd0, s_bytes[23:16]};
  assign gap_diff = hdr_seq - expected_q;
  assign dup_diff = expected_q - seq_next;
  assign step     = (remaining_q >= 16'd8) ? 16'd8 : remaining_q;

  always_comb begin
    rem_mask = 8'h00;
    for (int i = 0; i < 8; i++) rem_mask[i] = (remaining_q > 16'(i));
  end

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    synced_d    = synced_q && !seq_resync;
    remaining_d = remaining_q;
    emit        = 1'b0;
    fwd         = 1'b1;
    emit_en     = s_byte_enables;
    gap_d       = 1'b0;
    dup_d       = 1'b0;
    len_err_d   = 1'b0;
    drop_inc    = 1'b0;
    case (state_q)
      HDR: if (accept) begin
        if (s_byte_enables != 8'hFF || hdr_len < 16'd8) begin
          len_err_d = 1'b1;
          drop_inc  = 1'b1;
        end else if (cfg_unit != '0 && s_bytes[24 +: UNIT_W] != cfg_unit) begin
          drop_inc    = 1'b1;
          remaining_d = hdr_len - 16'd8;
          if (hdr_len > 16'd8) state_d = DROP;
        end else begin
          // synced_d already has a same-cycle resync folded in
          if (hdr_seq == 32'd0) begin
            fwd = 1'b1;
          end else if (!synced_d || hdr_seq == expected_q) begin
            expected_d = seq_next;
            synced_d   = 1'b1;
          end else if (!gap_diff[31] && gap_diff != 32'd0) begin
            gap_d      = 1'b1;
            expected_d = seq_next;
          end else if (!dup_diff[31]) begin
            dup_d    = 1'b1;
            drop_inc = 1'b1;
            fwd      = 1'b0;
          end else begin
            expected_d = seq_next;
          end
          remaining_d = hdr_len - 16'd8;
          emit        = fwd;
          emit_en     = 8'hFF;
          if (hdr_len != 16'd8) state_d = fwd ? FWD : DROP;
        end
      end
      FWD: if (accept) begin
        emit        = 1'b1;
        emit_en     = s_byte_enables & rem_mask;
        len_err_d   = (s_byte_enables != rem_mask);
        remaining_d = remaining_q - step;
        if (remaining_q <= 16'd8) state_d = HDR;
      end
      DROP: if (accept) begin
        remaining_d = remaining_q - step;
        if (remaining_q <= 16'd8) state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  // Output register plus one skid entry; the skid only fills while the output is stalled.
  assign out_ready = !m_valid_q || m_ready;

  always_comb begin
    m_valid_d    = m_valid_q;
    m_bytes_d    = m_bytes_q;
    m_en_d       = m_en_q;
    skid_valid_d = skid_valid_q;
    skid_bytes_d = skid_bytes_q;
    skid_en_d    = skid_en_q;
    if (skid_valid_q) begin
      if (out_ready) begin
        m_valid_d    = 1'b1;
        m_bytes_d    = skid_bytes_q;
        m_en_d       = skid_en_q;
        skid_valid_d = 1'b0;
      end
    end else if (emit) begin
      if (out_ready) begin
        m_valid_d = 1'b1;
        m_bytes_d = s_bytes;
        m_en_d    = emit_en;
      end else begin
        skid_valid_d = 1'b1;
        skid_bytes_d = s_bytes;
        skid_en_d    = emit_en;
      end
    end else if (out_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk40) begin
    if (reset) begin
      state_q      <= HDR;
      expected_q   <= '0;
      synced_q     <= 1'b0;
      remaining_q  <= '0;
      m_valid_q    <= 1'b0;
      m_bytes_q    <= '0;
      m_en_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_bytes_q <= '0;
      skid_en_q    <= '0;
      gap_q        <= 1'b0;
      dup_q        <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      synced_q     <= synced_d;
      remaining_q  <= remaining_d;
      m_valid_q    <= m_valid_d;
      m_bytes_q    <= m_bytes_d;
      m_en_q       <= m_en_d;
      skid_valid_q <= skid_valid_d;
      skid_bytes_q <= skid_bytes_d;
      skid_en_q    <= skid_en_d;
      gap_q        <= gap_d;
      dup_q        <= dup_d;
      len_err_q    <= len_err_d;
    end
  end

`ifdef PITCH_SEQ_STATS_EN
  logic [CNT_W-1:0] gap_count_q, gap_count_d, drop_count_q, drop_count_d;

  always_comb begin
    gap_count_d  = gap_count_q;
    drop_count_d = drop_count_q;
    if (gap_d && gap_count_q != '1) gap_count_d = gap_count_q + CNT_W'(1);
    if (drop_inc && drop_count_q != '1) drop_count_d = drop_count_q + CNT_W'(1);
  end

  always_ff @(posedge Clk40) begin
    if (reset) begin
      gap_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      gap_count_q  <= gap_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign gap_count  = gap_count_q;
  assign drop_count = drop_count_q;
`else
  logic unused_stats;
  assign unused_stats = drop_inc;
  assign gap_count    = '0;
  assign drop_count   = '0;
`endif

  assign s_ready        = !skid_valid_q && !reset;
  assign m_data_valid   = m_valid_q;
  assign m_bytes        = m_bytes_q;
  assign m_byte_enables = m_en_q;
  assign gap_pulse      = gap_q;
  assign dup_pulse      = dup_q;
  assign len_err_pulse  = len_err_q;
  assign dbg_state      = state_q;
endmodule
